// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame deframer.
//   state_t    : deframer FSM states
//   err_code_t : reason reported with frame_err
//   DEFAULT_SYNC_BYTE : default frame start marker
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        EMIT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: register array with one synchronous write port and one
// combinational read port. Contents are not reset.
// Ports:
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write byte
//   i_raddr : read index
//   o_rdata : byte at i_raddr (combinational)
module uart_frame_buf #(
    parameter int MAX_LEN = 16
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [$clog2(MAX_LEN+1)-1:0]   i_waddr,
    input  logic [7:0]                     i_wdata,
    input  logic [$clog2(MAX_LEN+1)-1:0]   i_raddr,
    output logic [7:0]                     o_rdata
);

    localparam int AW    = $clog2(MAX_LEN + 1);
    // The array spans the full index range so every index value is in
    // bounds; only slots below MAX_LEN are ever written or read.
    localparam int SLOTS = 1 << AW;

    logic [7:0] r_mem [SLOTS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Packet deframer downstream of uart_rx. Hunts for SYNC_BYTE, reads a
// length byte, len payload bytes and an XOR checksum (seeded with len).
// Valid frames are replayed from an internal buffer with out_last on the
// final byte; bad frames are dropped with a frame_err pulse and err_code.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_data/valid/ready   : input byte stream (valid/ready)
//   out_data/valid/ready  : payload byte stream (valid/ready)
//   out_last          : final payload byte of the frame
//   frame_ok          : one-cycle pulse, frame accepted (first EMIT cycle)
//   frame_err         : one-cycle pulse, frame dropped
//   err_code          : reason for the last frame_err, held until next error
// Handshake: a byte moves on a posedge where valid && ready are both high;
// while valid is high and ready is low, data and last are held stable.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        r_state;
    err_code_t     r_err_code;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_wr_idx;
    logic [LW-1:0] r_rd_idx;
    logic [7:0]    r_chk;
    logic [TW-1:0] r_idle;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_frame_ok;
    logic          r_frame_err;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_in_frame;
    logic          w_timeout;
    logic          w_buf_we;
    logic [7:0]    w_rd_data;

    assign in_ready   = !rst && (r_state != EMIT);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_in_frame = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK);
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign w_timeout  = TO_EN && w_in_frame && !w_in_fire && (r_idle == IDLE_LAST);
    assign w_buf_we   = (r_state == PAYLOAD) && w_in_fire;

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .i_clk   (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_idx),
        .i_wdata (in_data),
        .i_raddr (r_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_err_code  <= ERR_NONE;
            r_len       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_chk       <= '0;
            r_idle      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_in_frame && !w_in_fire) begin
                r_idle <= r_idle + TW'(1);
            end else begin
                r_idle <= '0;
            end

            case (r_state)
                HUNT: begin
                    if (w_in_fire && (in_data == SYNC_BYTE)) begin
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    if (w_in_fire) begin
                        if ((in_data == 8'd0) || (int'(in_data) > MAX_LEN)) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_BAD_LEN;
                            r_state     <= HUNT;
                        end else begin
                            r_len    <= LW'(in_data);
                            r_chk    <= in_data;
                            r_wr_idx <= '0;
                            r_state  <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_in_fire) begin
                        r_chk    <= r_chk ^ in_data;
                        r_wr_idx <= r_wr_idx + LW'(1);
                        if (r_wr_idx == (r_len - LW'(1))) begin
                            r_state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (w_in_fire) begin
                        if (in_data == r_chk) begin
                            r_state     <= EMIT;
                            r_frame_ok  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_rd_idx    <= '0;
                            r_out_last  <= (r_len == LW'(1));
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_BAD_CHK;
                            r_state     <= HUNT;
                        end
                    end
                end
                EMIT: begin
                    if (w_out_fire) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= HUNT;
                        end else begin
                            r_rd_idx   <= r_rd_idx + LW'(1);
                            r_out_last <= ((r_rd_idx + LW'(1)) == (r_len - LW'(1)));
                        end
                    end
                end
                default: begin
                    r_state <= HUNT;
                end
            endcase

            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TIMEOUT;
                r_state     <= HUNT;
            end
        end
    end

    assign out_data  = w_rd_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx (MAX_LEN=16, TIMEOUT_CYCLES=50).
module tb_uart_frame_rx;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    logic [8:0] got_q[$];
    int         got_cyc_q[$];
    logic [8:0] exp_q[$];
    int ok_cnt = 0;
    int err_cnt = 0;
    int ok_cyc = -1;
    int err_cyc = -1;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                got_cyc_q.push_back(cyc);
            end
            if (frame_ok) begin
                ok_cnt = ok_cnt + 1;
                ok_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt = err_cnt + 1;
                err_cyc = cyc;
            end
            if (frame_ok && frame_err) both_cnt = both_cnt + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        ok_cnt  = 0;
        err_cnt = 0;
        ok_cyc  = -1;
        err_cyc = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
        total++; if (frame_ok !== 1'b0) begin bad++; $display("FAIL rst_frame_ok: got %0b want 0", frame_ok); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err: got %0b want 0", frame_err); end
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %0b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        int chk_acc;
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        chk_acc = acc_cyc;
        wait_cycles(10);
        exp_q = '{9'h011, 9'h022, 9'h133};
        total++; if (got_q.size() !== 3) begin bad++; $display("FAIL good_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL good_byte%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL good_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (ok_cnt !== 1) begin bad++; $display("FAIL good_ok_cnt: got %0d want 1", ok_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt); end
        total++; if (ok_cyc !== chk_acc) begin bad++; $display("FAIL good_latency: frame_ok cycle %0d want %0d", ok_cyc, chk_acc); end
        total++;
        if (got_cyc_q.size() == 0) begin bad++; $display("FAIL good_first_out_cycle: no output, want cycle %0d", chk_acc); end
        else if (got_cyc_q[0] !== chk_acc) begin bad++; $display("FAIL good_first_out_cycle: got %0d want %0d", got_cyc_q[0], chk_acc); end
    endtask

    task automatic test_bad_chk();
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'h55); send_byte(8'h00);
        wait_cycles(5);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL badchk_err_cnt: got %0d want 1", err_cnt); end
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL badchk_code: got %0d want 2", err_code); end
        total++; if (got_q.size() !== 0 || ok_cnt !== 0) begin bad++; $display("FAIL badchk_no_out: outs=%0d ok=%0d want 0 0", got_q.size(), ok_cnt); end
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        wait_cycles(5);
        total++;
        if (got_q.size() !== 1) begin bad++; $display("FAIL badchk_next_count: got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 9'h17E) begin bad++; $display("FAIL badchk_next_byte: got %h want 17e", got_q[0]); end
        total++; if (ok_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL badchk_next_pulses: ok=%0d err=%0d want 1 0", ok_cnt, err_cnt); end
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL badchk_code_held: got %0d want 2", err_code); end
    endtask

    task automatic test_bad_len();
        clear_mon();
        send_byte(8'hA5); send_byte(8'h00);
        wait_cycles(3);
        total++; if (err_cnt !== 1 || err_code !== 2'd1) begin bad++; $display("FAIL badlen_zero: err=%0d code=%0d want 1 1", err_cnt, err_code); end
        send_byte(8'hA5); send_byte(8'h11);
        wait_cycles(3);
        total++; if (err_cnt !== 2 || err_code !== 2'd1) begin bad++; $display("FAIL badlen_17: err=%0d code=%0d want 2 1", err_cnt, err_code); end
        // A5 as a bad length is consumed, so 01 5A 5B must be discarded.
        send_byte(8'hA5); send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        wait_cycles(3);
        total++; if (err_cnt !== 3 || err_code !== 2'd1) begin bad++; $display("FAIL badlen_sync_val: err=%0d code=%0d want 3 1", err_cnt, err_code); end
        total++; if (got_q.size() !== 0 || ok_cnt !== 0) begin bad++; $display("FAIL badlen_no_out: outs=%0d ok=%0d want 0 0", got_q.size(), ok_cnt); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL badlen_in_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        wait_cycles(5);
        total++;
        if (got_q.size() !== 1) begin bad++; $display("FAIL badlen_recover_count: got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 9'h15A) begin bad++; $display("FAIL badlen_recover_byte: got %h want 15a", got_q[0]); end
    endtask

    task automatic test_garbage_sync_in_payload();
        clear_mon();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA4);
        wait_cycles(5);
        total++;
        if (got_q.size() !== 1) begin bad++; $display("FAIL garbage_count: got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 9'h1A5) begin bad++; $display("FAIL garbage_byte: got %h want 1a5", got_q[0]); end
        total++; if (ok_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL garbage_pulses: ok=%0d err=%0d want 1 0", ok_cnt, err_cnt); end
    endtask

    task automatic test_backpressure();
        int k;
        logic       have_prev;
        logic [8:0] prev;
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(i)});
        k = 0;
        have_prev = 1'b0;
        prev = '0;
        while (got_q.size() < 16 && k < 200) begin
            out_ready = (k % 2 == 0);
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0 in EMIT (k=%0d)", in_ready, k); end
                if (have_prev) begin
                    total++;
                    if ({out_last, out_data} !== prev) begin bad++; $display("FAIL bp_stall_stable: got %h want %h", {out_last, out_data}, prev); end
                end
            end
            have_prev = out_valid && !out_ready;
            prev = {out_last, out_data};
            @(posedge clk);
            #1;
            k++;
        end
        out_ready = 1'b1;
        wait_cycles(2);
        total++; if (got_q.size() !== 16) begin bad++; $display("FAIL bp_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL bp_byte%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (ok_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL bp_pulses: ok=%0d err=%0d want 1 0", ok_cnt, err_cnt); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_back_hunt: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int t0;
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        t0 = acc_cyc;
        wait_cycles(60);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL to_err_cnt: got %0d want 1", err_cnt); end
        total++; if (err_cyc !== t0 + 50) begin bad++; $display("FAIL to_cycle: got %0d want %0d", err_cyc, t0 + 50); end
        total++; if (err_code !== 2'd3) begin bad++; $display("FAIL to_code: got %0d want 3", err_code); end
        total++; if (got_q.size() !== 0 || ok_cnt !== 0) begin bad++; $display("FAIL to_no_out: outs=%0d ok=%0d want 0 0", got_q.size(), ok_cnt); end
    endtask

    task automatic test_reset_mid_emit();
        clear_mon();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        wait_cycles(3);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h7E) begin bad++; $display("FAIL rme_stalled: valid=%0b data=%h want 1 7e", out_valid, out_data); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rme_in_ready_rst: got %0b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL rme_out_cleared: valid=%0b last=%0b want 0 0", out_valid, out_last); end
        total++; if (frame_err !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL rme_err_cleared: err=%0b code=%0d want 0 0", frame_err, err_code); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rme_in_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3);
        send_byte(8'h3C); send_byte(8'hFD);
        wait_cycles(6);
        exp_q = '{9'h0C3, 9'h13C};
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL rme_fresh_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL rme_fresh_byte%0d: missing, want %h", i, exp_q[i]); end
            else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rme_fresh_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (ok_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL rme_fresh_pulses: ok=%0d err=%0d want 1 0", ok_cnt, err_cnt); end
    endtask

    task automatic test_exclusive_pulses();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL ok_err_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_bad_len();
        test_garbage_sync_in_payload();
        test_backpressure();
        test_timeout();
        test_reset_mid_emit();
        test_exclusive_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Packet deframer that sits directly downstream of uart_rx and consumes its valid/ready byte stream. It hunts for a sync byte, then reads a length byte, a payload and an XOR checksum. It buffers the payload internally and forwards it with a last flag only if the frame is valid. Bad frames are dropped whole and reported through a one-cycle error pulse and an error code.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, maximum payload length in bytes (>=1)
TIMEOUT_CYCLES, 100000, allowed idle clk cycles between bytes inside a frame; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_data  in  8  byte from uart_rx
in_valid  in  1  in_data valid
in_ready  out  1  deframer accepts in_data
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  out_data is the final payload byte of the frame
frame_ok  out  1  one-cycle pulse: frame accepted
frame_err  out  1  one-cycle pulse: frame dropped
err_code  out  2  reason for the last frame_err: 0 NONE, 1 BAD_LEN, 2 BAD_CHK, 3 TIMEOUT; held until the next error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state HUNT; in_ready=0 while rst=1; out_valid=0, out_last=0, frame_ok=0, frame_err=0, err_code=0. out_data and buffer contents are don't-care.
- Byte transfers: an input byte is taken on a posedge with in_valid&&in_ready. An output byte is transferred on a posedge with out_valid&&out_ready.
- in_ready is 1 in HUNT, LEN, PAYLOAD and CHK. It is 0 in EMIT, which applies backpressure to uart_rx.
- HUNT: bytes other than SYNC_BYTE are discarded. On SYNC_BYTE go to LEN.
- LEN: if the byte is 0 or greater than MAX_LEN, pulse frame_err with BAD_LEN and go to HUNT. The bad byte is consumed and is not re-examined as a sync byte. Otherwise store len, seed chk=len, set wr_idx=0 and go to PAYLOAD.
- PAYLOAD: write the byte to buf[wr_idx] and update chk^=byte. After the len-th byte go to CHK. A SYNC_BYTE value inside the payload is ordinary data; no resync.
- CHK: if the byte equals chk, go to EMIT and pulse frame_ok in the first EMIT cycle. Otherwise pulse frame_err with BAD_CHK and go to HUNT.
- Latency: the first out_valid is in the cycle after the CHK byte is accepted, the same cycle as frame_ok.
- EMIT:
  - out_valid=1 and out_data=buf[rd_idx]; out_last=1 when rd_idx==len-1.
  - rd_idx increments on each output handshake.
  - While out_valid && !out_ready, out_data and out_last stay stable.
  - The handshake on the last byte returns the block to HUNT; in_ready=1 in the following cycle.
- Timeout:
  - An idle counter clears on every accepted byte and counts in LEN, PAYLOAD and CHK.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte, pulse frame_err with TIMEOUT and go to HUNT.
  - If a byte is accepted in the same cycle the timeout would fire, the byte wins and no timeout occurs.
  - There is no timeout in HUNT or EMIT.
- Reset mid-frame or mid-EMIT: the next cycle is in HUNT, all outputs are at their reset values, and the partial frame is lost with no error pulse.
- Widths:
  - len and the buffer indices are $clog2(MAX_LEN+1) bits.
  - The idle counter is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1.
  - chk is 8 bits.
- frame_ok and frame_err are never asserted in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CHK, EMIT}
  - err_code enum {ERR_NONE, ERR_BAD_LEN, ERR_BAD_CHK, ERR_TIMEOUT}
  - default SYNC_BYTE constant
- One sub-module, uart_frame_buf: MAX_LEN x 8 simple dual-port register array with one write port and a combinational read port.

Test Plan:
1. Good frame: A5 03 11 22 33 03 with out_ready=1 -> out 11, 22, 33, with out_last only on 33. One frame_ok pulse, in the cycle 11 first appears. No frame_err.
2. Bad checksum: A5 02 AA 55 00 (correct value FD) -> no out_valid; frame_err with err_code=2. A following A5 01 7E 7F -> out 7E with out_last=1 and frame_ok.
3. Bad length: A5 00 -> frame_err with err_code=1. A5 11 (17 > MAX_LEN) -> frame_err with err_code=1. In both cases no output, and the block is back in HUNT.
4. Leading garbage and sync inside payload: 00 FF A5 01 A5 A4 -> single output A5 with out_last=1 and frame_ok.
5. Backpressure: frame A5 10 00..0F 10 with out_ready toggling 1,0,1,0 -> 16 bytes in order. out_data is stable during stalls, in_ready=0 throughout EMIT, and out_last is on 0F only.
6. Timeout and reset:
   - TIMEOUT_CYCLES=50; send A5 02 11, then idle -> frame_err with err_code=3 exactly 50 cycles after 11 is accepted.
   - Separately, assert rst for 1 cycle mid-EMIT -> out_valid=0 the next cycle, then a fresh good frame decodes correctly.
